// File: rtl/operb_select_stage_pkg.sv
// Shared definitions for the operand-B select stage: source indices, skid-stage
// state encoding and the select range check.
package operb_select_stage_pkg;

  localparam int OPB_SRC_PC  = 0;
  localparam int OPB_SRC_IMM = 1;
  localparam int OPB_SRC_RS2 = 2;
  localparam int OPB_SRC_FWD = 3;

  typedef enum logic [1:0] {
    OPB_EMPTY = 2'd0,
    OPB_ONE   = 2'd1,
    OPB_TWO   = 2'd2
  } opb_state_e;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned nsrc);
    return sel < nsrc;
  endfunction

endpackage

// File: rtl/operb_select_stage_if.sv
// Handshake/bus bundle between the decode side (master) and the operand-B
// select stage (slave).
interface operb_select_stage_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SEL_W = 3
);

  logic [NSRC*WIDTH-1:0] src_bus;
  logic [SEL_W-1:0]      sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;

  modport master (
    output src_bus, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  src_bus, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

endinterface

// File: rtl/operb_select_stage_skid_buffer.sv
// Two-slot valid/ready skid stage with registered in_ready and synchronous flush.
//   state     | meaning
//   OPB_EMPTY | no beat held
//   OPB_ONE   | main register holds the beat shown on out_data
//   OPB_TWO   | main and skid both full, upstream stalled
module skid_buffer
  import operb_select_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  opb_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush leaves the data registers alone so out_data keeps its last value.
    if (flush) begin
      state_d = OPB_EMPTY;
    end else begin
      case (state_q)
        OPB_EMPTY: begin
          if (accept) begin
            state_d = OPB_ONE;
            main_d  = in_data;
          end
        end
        OPB_ONE: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = OPB_TWO;
            skid_d  = in_data;
          end else if (drain) begin
            state_d = OPB_EMPTY;
          end
        end
        OPB_TWO: begin
          if (drain) begin
            state_d = OPB_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = OPB_EMPTY;
      endcase
    end
    out_valid_d = (state_d != OPB_EMPTY);
    in_ready_d  = (state_d != OPB_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OPB_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/operb_select_stage.sv
// Registered operand-B selector: picks one of NSRC sources at accept time and
// feeds it through a two-slot skid stage; flags out-of-range selects.
module operb_select_stage
  import operb_select_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operb_select_stage_if.slave   io
);

  if (NSRC < 2 || NSRC > 8 || SEL_W < $clog2(NSRC)) begin : g_param_check
    $error("operb_select_stage: unsupported NSRC/SEL_W combination");
  end

  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             accept;
  logic             sel_err_q, sel_err_d;

  // Out-of-range selects fall back to the PC source.
  always_comb begin
    sel_data = io.src_bus[OPB_SRC_PC*WIDTH +: WIDTH];
    for (int k = 1; k < NSRC; k++) begin
      if (io.sel == SEL_W'(k)) sel_data = io.src_bus[k*WIDTH +: WIDTH];
    end
  end

  assign sel_ok = sel_in_range(32'(io.sel), NSRC);
  assign accept = io.in_valid & io.in_ready & ~io.flush;

  always_comb begin
    sel_err_d = sel_err_q | (accept & ~sel_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign io.sel_err = sel_err_q;

  skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (io.flush),
    .in_data   (sel_data),
    .in_valid  (io.in_valid),
    .in_ready  (io.in_ready),
    .out_data  (io.out_data),
    .out_valid (io.out_valid),
    .out_ready (io.out_ready)
  );

endmodule

// File: tb/tb_operb_select_stage.sv
// Directed plus random bench for operb_select_stage against a queue-based model.
module tb_operb_select_stage;
  import operb_select_stage_pkg::*;

  localparam int WIDTH = 32;
  localparam int NSRC  = 4;
  localparam int SEL_W = 3;

  logic clk;
  logic rst_n;

  operb_select_stage_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) ifc ();

  operb_select_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] src [NSRC];
  logic [WIDTH-1:0] exp_q [$];
  bit               m_ready;
  bit               m_err;
  bit               m_acc;
  logic [WIDTH-1:0] last_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ready  = 1'b1;
    m_err    = 1'b0;
    last_out = '0;
  endtask

  task automatic drive(input bit v, input logic [SEL_W-1:0] s, input bit f, input bit r);
    for (int k = 0; k < NSRC; k++) ifc.src_bus[k*WIDTH +: WIDTH] = src[k];
    ifc.sel       = s;
    ifc.in_valid  = v;
    ifc.flush     = f;
    ifc.out_ready = r;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 64'(ifc.out_valid), 64'(exp_q.size() > 0));
    check({tag, ".out_data"},  64'(ifc.out_data),  64'((exp_q.size() > 0) ? exp_q[0] : last_out));
    check({tag, ".in_ready"},  64'(ifc.in_ready),  64'(m_ready));
    check({tag, ".sel_err"},   64'(ifc.sel_err),   64'(m_err));
  endtask

  // One clock: update the FIFO model from the inputs driven for this edge, then compare.
  task automatic step(input string tag);
    int unsigned s;
    bit drain;
    @(posedge clk);
    m_acc = 1'b0;
    s = 32'(ifc.sel);
    if (ifc.flush) begin
      exp_q.delete();
    end else begin
      drain = (exp_q.size() > 0) && ifc.out_ready;
      m_acc = ifc.in_valid && m_ready;
      if (drain) void'(exp_q.pop_front());
      if (m_acc) begin
        exp_q.push_back((s < NSRC) ? src[s] : src[0]);
        if (s >= NSRC) m_err = 1'b1;
      end
    end
    m_ready = (exp_q.size() < 2);
    if (exp_q.size() > 0) last_out = exp_q[0];
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bit got;
    rst_n = 1'b1;
    for (int k = 0; k < NSRC; k++) src[k] = '0;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();

    #2 rst_n = 1'b0;
    #1 check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Streaming, one beat per cycle
    src[0] = 32'h10; src[1] = 32'h20; src[2] = 32'h30; src[3] = 32'h40;
    drive(1'b1, SEL_W'(OPB_SRC_PC),  1'b0, 1'b1); step("stream0");
    drive(1'b1, SEL_W'(OPB_SRC_IMM), 1'b0, 1'b1); step("stream1");
    drive(1'b1, SEL_W'(OPB_SRC_RS2), 1'b0, 1'b1); step("stream2");
    drive(1'b1, SEL_W'(OPB_SRC_FWD), 1'b0, 1'b1); step("stream3");
    drive(1'b0, '0, 1'b0, 1'b1);                  step("stream_idle");

    // Back-pressure: third beat waits until the stage drains
    src[0] = 32'hA0; src[1] = 32'hA1; src[2] = 32'hA2; src[3] = 32'hA3;
    drive(1'b1, 3'd0, 1'b0, 1'b0); step("bp_beat0");
    drive(1'b1, 3'd1, 1'b0, 1'b0); step("bp_beat1");
    drive(1'b1, 3'd2, 1'b0, 1'b0); step("bp_beat2_stalled");
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      drive(1'b1, 3'd2, 1'b0, 1'b1);
      step("bp_release");
      got = m_acc;
    end
    total++;
    assert (got) else begin
      bad++;
      $error("FAIL bp_third_accept observed=timeout expected=accepted");
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    repeat (3) step("bp_drain");

    // Bad select falls back to source 0 and sets the sticky flag
    src[0] = 32'hDEAD_BEEF;
    drive(1'b1, 3'd5, 1'b0, 1'b1); step("badsel");
    drive(1'b0, '0, 1'b0, 1'b1);   step("badsel_idle");

    // Flush from TWO with a beat offered in the same cycle
    src[0] = 32'h1111; src[1] = 32'h2222; src[2] = 32'h3333;
    drive(1'b1, 3'd0, 1'b0, 1'b0); step("fl_fill0");
    drive(1'b1, 3'd1, 1'b0, 1'b0); step("fl_fill1");
    src[2] = 32'h5A5A_5A5A;
    drive(1'b1, 3'd2, 1'b1, 1'b0); step("flush_two");
    drive(1'b0, '0, 1'b0, 1'b1);   repeat (2) step("flush_after");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NSRC; k++) src[k] = $urandom;
      drive(1'($urandom_range(0, 3) != 0),
            SEL_W'(($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3)),
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) != 0));
      step("random");
    end

    // Fill, then asynchronous reset in the middle of a cycle
    drive(1'b1, 3'd6, 1'b0, 1'b0); step("pre_rst0");
    drive(1'b1, 3'd1, 1'b0, 1'b0); step("pre_rst1");
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("async_reset");
    drive(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    step("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
